// File: rtl/ram_copy_dma.sv
// rtl/ram_copy_dma.sv - block-copy engine with memmove ordering for a 1-cycle-latency RAM
module ram_copy_dma #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          start_i,
    input  logic [AW-1:0] src_i,
    input  logic [AW-1:0] dst_i,
    input  logic [AW-1:0] count_i,
    input  logic          abort_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          aborted_o,
    output logic [AW-1:0] ram_raddr_o,
    output logic          ram_re_o,
    input  logic [DW-1:0] ram_rdata_i,
    output logic [AW-1:0] ram_waddr_o,
    output logic [DW-1:0] ram_wdata_o,
    output logic          ram_we_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] src_q, src_d, dst_q, dst_d, cnt_q, cnt_d, idx_q, idx_d;
    logic          desc_q, desc_d, abort_seen_q, abort_seen_d;
    logic          busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
    logic          re_q, re_d, we_q, we_d;
    logic [AW-1:0] raddr_q, raddr_d, waddr_q, waddr_d;

    logic [AW-1:0] start_diff, last_off, idx_next;
    logic          start_desc;

    // Copy downwards only when the destination overlaps above the source (modular distance).
    assign start_diff = dst_i - src_i;
    assign start_desc = (start_diff != '0) && (start_diff < count_i);
    assign last_off   = cnt_q - AW'(1);
    assign idx_next   = idx_q + AW'(1);

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        desc_d       = desc_q;
        abort_seen_d = abort_seen_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        aborted_d    = aborted_q;
        re_d         = 1'b0;
        we_d         = 1'b0;
        raddr_d      = raddr_q;
        waddr_d      = waddr_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    src_d        = src_i;
                    dst_d        = dst_i;
                    cnt_d        = count_i;
                    idx_d        = '0;
                    desc_d       = start_desc;
                    abort_seen_d = 1'b0;
                    aborted_d    = 1'b0;
                    if (count_i == '0) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                        re_d    = 1'b1;
                        raddr_d = start_desc ? (src_i + count_i - AW'(1)) : src_i;
                    end
                end
            end
            S_RUN: begin
                // The word read this cycle arrives next cycle; write it there.
                we_d    = 1'b1;
                waddr_d = desc_q ? (dst_q + last_off - idx_q) : (dst_q + idx_q);
                if (abort_i) begin
                    abort_seen_d = 1'b1;
                end
                if (abort_i || (idx_q == last_off)) begin
                    state_d = S_DRAIN;
                end else begin
                    re_d    = 1'b1;
                    idx_d   = idx_next;
                    raddr_d = desc_q ? (src_q + last_off - idx_next) : (src_q + idx_next);
                end
            end
            S_DRAIN: begin
                state_d   = S_FIN;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                aborted_d = abort_seen_q | abort_i;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            desc_q       <= 1'b0;
            abort_seen_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            re_q         <= 1'b0;
            we_q         <= 1'b0;
            raddr_q      <= '0;
            waddr_q      <= '0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            desc_q       <= desc_d;
            abort_seen_q <= abort_seen_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            re_q         <= re_d;
            we_q         <= we_d;
            raddr_q      <= raddr_d;
            waddr_q      <= waddr_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign aborted_o   = aborted_q;
    assign ram_re_o    = re_q;
    assign ram_we_o    = we_q;
    assign ram_raddr_o = raddr_q;
    assign ram_waddr_o = waddr_q;
    assign ram_wdata_o = ram_rdata_i;

endmodule

// File: tb/tb_ram_copy_dma.sv
// tb/tb_ram_copy_dma.sv - randomized self-checking bench for ram_copy_dma against a memmove model
module tb_ram_copy_dma;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic [15:0] src, dst, count;
    logic        busy, done, aborted;
    logic [15:0] ram_raddr, ram_waddr, ram_wdata;
    logic [15:0] ram_rdata = '0;
    logic        ram_re, ram_we;

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_copy_dma #(.AW(16), .DW(16)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (start),
        .src_i       (src),
        .dst_i       (dst),
        .count_i     (count),
        .abort_i     (abort),
        .busy_o      (busy),
        .done_o      (done),
        .aborted_o   (aborted),
        .ram_raddr_o (ram_raddr),
        .ram_re_o    (ram_re),
        .ram_rdata_i (ram_rdata),
        .ram_waddr_o (ram_waddr),
        .ram_wdata_o (ram_wdata),
        .ram_we_o    (ram_we)
    );

    // Simulation RAM: synchronous write, one-cycle read latency.
    always @(posedge clk) begin
        if (ram_re) ram_rdata <= mem[ram_raddr];
        if (ram_we) mem[ram_waddr] <= ram_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] v);
        mem[a] <= v;
        ref_mem[a] = v;
    endtask

    task automatic check_window(input string tag, input logic [15:0] base, input int n);
        int bad = 0;
        logic [15:0] a;
        for (int i = -4; i < n + 4; i++) begin
            a = base + 16'(i);
            if (mem[a] !== ref_mem[a]) bad++;
        end
        check(tag, bad, 0);
    endtask

    task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                            input int abort_at, input int restart_at);
        logic [15:0] diff, a, exp_addr;
        logic        dsc, abt, e_re, e_we, e_busy, e_done, e_ab;
        logic [15:0] snap[$];
        int          m, done_c, k;
        diff = d - s;
        dsc  = (diff != 0) && (diff < n);
        m    = (abort_at >= 1 && abort_at <= int'(n)) ? abort_at : int'(n);
        done_c = (n == 0) ? 1 : m + 2;
        abt  = (n != 0) && (abort_at >= 1) && (abort_at <= m + 1);
        // Memmove model: snapshot the source, then place the m words actually moved.
        for (int i = 0; i < int'(n); i++) begin
            a = s + 16'(i);
            snap.push_back(ref_mem[a]);
        end
        for (int j = 0; j < m; j++) begin
            k = dsc ? int'(n) - 1 - j : j;
            a = d + 16'(k);
            ref_mem[a] = snap[k];
        end
        @(negedge clk);
        start = 1'b1; src = s; dst = d; count = n;
        for (int c = 1; c <= done_c + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin
                src = 16'($urandom); dst = 16'($urandom); count = 16'($urandom);
            end
            e_re   = (n != 0) && (c <= m);
            e_we   = (n != 0) && (c >= 2) && (c <= m + 1);
            e_busy = (n != 0) && (c <= m + 1);
            e_done = (c == done_c);
            e_ab   = (c >= done_c) ? abt : 1'b0;
            check($sformatf("ctl s%0h c%0d", s, c), {busy, done, ram_re, ram_we, aborted},
                  {e_busy, e_done, e_re, e_we, e_ab});
            if (e_re) begin
                exp_addr = dsc ? s + n - 16'(c) : s + 16'(c - 1);
                check($sformatf("raddr c%0d", c), ram_raddr, exp_addr);
            end
            if (e_we) begin
                exp_addr = dsc ? d + n - 16'(c - 1) : d + 16'(c - 2);
                check($sformatf("waddr c%0d", c), ram_waddr, exp_addr);
            end
            abort = (c == abort_at);
            start = (c == restart_at) && (restart_at <= done_c);
            if (start) begin
                src = 16'($urandom); dst = 16'($urandom); count = 16'($urandom_range(1, 20));
            end
        end
        start = 1'b0;
        abort = 1'b0;
        check_window($sformatf("mem dst %0h", d), d, int'(n));
        check_window($sformatf("mem src %0h", s), s, int'(n));
    endtask

    task automatic reset_mid_copy(input logic [15:0] s, input logic [15:0] d);
        @(negedge clk);
        start = 1'b1; src = s; dst = d; count = 16'd8;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        // Writes of indices 0 and 1 complete before the reset edge.
        for (int k = 0; k < 2; k++) ref_mem[d + 16'(k)] = ref_mem[s + 16'(k)];
        @(negedge clk);
        check("rst mid ctl", {busy, done, ram_re, ram_we, aborted}, 5'b0);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("post rst c%0d", c), {busy, done, ram_re, ram_we}, 4'b0);
        end
        check_window("rst mem", d, 8);
    endtask

    initial begin
        logic [15:0] s, d, n;
        int ab, rs;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        src = '0; dst = '0; count = '0;
        for (int i = 0; i < 65536; i++) poke(16'(i), 16'($urandom));
        repeat (2) @(negedge clk);
        check("reset ctl", {busy, done, ram_re, ram_we, aborted}, 5'b0);
        check("reset addr", {ram_raddr, ram_waddr}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) poke(16'h0100 + 16'(i), 16'hA0 + 16'(i));
        run_copy(16'h0100, 16'h0200, 16'd4, 0, 0);
        for (int i = 0; i < 5; i++) poke(16'h0010 + 16'(i), 16'(i + 1));
        run_copy(16'h0010, 16'h0012, 16'd5, 0, 0);
        for (int i = 0; i < 5; i++) poke(16'h0010 + 16'(i), 16'(i + 1));
        run_copy(16'h0012, 16'h0010, 16'd3, 0, 0);
        run_copy(16'hFFFE, 16'h0100, 16'd4, 0, 0);
        run_copy(16'h0300, 16'h0400, 16'd0, 0, 1);
        run_copy(16'h0500, 16'h0600, 16'd10, 3, 0);
        run_copy(16'h0700, 16'h0800, 16'd6, 0, 2);
        run_copy(16'h0700, 16'h0800, 16'd3, 0, 5);
        run_copy(16'h0900, 16'h0A00, 16'd3, 4, 0);
        run_copy(16'h0900, 16'h0A00, 16'd3, 5, 0);
        run_copy(16'hFFFC, 16'hFFFE, 16'd6, 0, 0);
        reset_mid_copy(16'h0B00, 16'h0C00);

        for (int t = 0; t < 40; t++) begin
            s = 16'($urandom);
            if ($urandom_range(0, 1) == 1) d = s + 16'($urandom_range(0, 24)) - 16'd12;
            else d = 16'($urandom);
            n  = 16'($urandom_range(0, 16));
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 19)) : 0;
            rs = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 18)) : 0;
            run_copy(s, d, n, ab, rs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
